ipsxe_floating_point_result_checker_v1_0: RTL and testbench

Latency-independent on-board result checker for the floating-point IP example designs. It receives expected (golden) words from the stimulus side into an internal FIFO and consumes the core's result stream. Each result is compared in order against the oldest queued golden word, with pass and fail events counted. It replaces fixed-depth golden delay lines, so the same checker works for any core latency configuration.

---
 rtl/ipsxe_floating_point_result_checker_v1_0_if.sv | 47 ++++
 rtl/ipsxe_floating_point_result_checker_v1_0.sv | 238 +++++++++++++++++++++++
 tb/tb_ipsxe_floating_point_result_checker_v1_0.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipsxe_floating_point_result_checker_v1_0_if.sv
// ----------------------------------------------------------------------------
// ipsxe_floating_point_result_checker_v1_0_if
//
// Stream bundle between the stimulus/core side and the result checker.
//
// Signals:
//   i_golden_tdata        expected (golden) result word
//   i_golden_tvalid       golden word valid
//   o_golden_tready       checker can accept a golden word
//   i_axi4s_result_tdata  result word produced by the core under test
//   i_axi4s_result_tvalid result word valid (no ready: always accepted)
//
// Handshake: a golden word transfers on a rising clock edge where
// i_golden_tvalid and o_golden_tready are both high. The source may raise
// tvalid independently of tready and must hold data stable until the transfer.
// The result stream has no back-pressure; every cycle with
// i_axi4s_result_tvalid high delivers one result word.
//
// Modports:
//   master  drives the golden and result streams (stimulus / core side)
//   slave   the checker
// ----------------------------------------------------------------------------
interface ipsxe_floating_point_result_checker_v1_0_if #(
  parameter int TDATA_OUT_WIDTH = 32
);
  logic [TDATA_OUT_WIDTH-1:0] i_golden_tdata;
  logic                       i_golden_tvalid;
  logic                       o_golden_tready;
  logic [TDATA_OUT_WIDTH-1:0] i_axi4s_result_tdata;
  logic                       i_axi4s_result_tvalid;

  modport master (
    output i_golden_tdata,
    output i_golden_tvalid,
    input  o_golden_tready,
    output i_axi4s_result_tdata,
    output i_axi4s_result_tvalid
  );

  modport slave (
    input  i_golden_tdata,
    input  i_golden_tvalid,
    output o_golden_tready,
    input  i_axi4s_result_tdata,
    input  i_axi4s_result_tvalid
  );
endinterface

// File: rtl/ipsxe_floating_point_result_checker_v1_0.sv
// ----------------------------------------------------------------------------
// ipsxe_floating_point_result_checker_v1_0
//
// Latency-independent result checker for the floating-point IP example
// designs. Golden words are queued in a FIFO; every result word is compared
// in order with the oldest queued golden word. Pass/fail events are counted
// and the checker finishes after VECTOR_NUM results.
//
// Ports:
//   i_aclk              clock, rising edge
//   i_areset_n          asynchronous active-low reset
//   s_if (slave)        golden stream in (valid/ready), result stream in
//   o_pass_cnt          matching results (saturating)
//   o_fail_cnt          mismatching or unexpected results (saturating)
//   o_overflow          sticky: golden word offered while FIFO full
//   o_unexpected        sticky: result arrived while FIFO empty
//   o_done              VECTOR_NUM results have been checked
//   o_success           done with no failures, overflow or unexpected result
//   o_dbg_state         FSM state (0 IDLE, 1 RUN, 2 DONE)
//   o_dbg_fifo_count    golden FIFO occupancy
//   o_dbg_nan_pair      last compared pair had a NaN on both sides
//
// Build option:
//   IPSXE_FLT_CHECKER_NAN_EQ_EN  when defined, any NaN result matches any NaN
//                                golden word; otherwise strict bitwise compare.
// ----------------------------------------------------------------------------
module ipsxe_floating_point_result_checker_v1_0 #(
  parameter int TDATA_OUT_WIDTH = 32,
  parameter int EXP_WIDTH       = 8,
  parameter int MAN_WIDTH       = 23,
  parameter int FIFO_DEPTH      = 16,
  parameter int VECTOR_NUM      = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                           i_aclk,
  input  logic                           i_areset_n,
  ipsxe_floating_point_result_checker_v1_0_if.slave s_if,
  output logic [CNT_WIDTH-1:0]           o_pass_cnt,
  output logic [CNT_WIDTH-1:0]           o_fail_cnt,
  output logic                           o_overflow,
  output logic                           o_unexpected,
  output logic                           o_done,
  output logic                           o_success,
  output logic [1:0]                     o_dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]    o_dbg_fifo_count,
  output logic                           o_dbg_nan_pair
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0]     FULL_CNT = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] VEC_CNT  = CNT_WIDTH'(VECTOR_NUM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // NaN: exponent field all ones and a nonzero mantissa field.
  function automatic logic is_nan(input logic [TDATA_OUT_WIDTH-1:0] w);
    return (&w[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH]) && (|w[MAN_WIDTH-1:0]);
  endfunction

  function automatic logic words_match(input logic [TDATA_OUT_WIDTH-1:0] g,
                                       input logic [TDATA_OUT_WIDTH-1:0] r);
`ifdef IPSXE_FLT_CHECKER_NAN_EQ_EN
    return (g == r) || (is_nan(g) && is_nan(r));
`else
    return (g == r);
`endif
  endfunction

  // Registered state
  state_t                     state_q,      state_d;
  logic [TDATA_OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [TDATA_OUT_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q,     rd_ptr_d;
  logic [OCC_W-1:0]           count_q,      count_d;
  logic                       cmp_valid_q,  cmp_valid_d;
  logic                       cmp_match_q,  cmp_match_d;
  logic                       cmp_unexp_q,  cmp_unexp_d;
  logic                       cmp_nan_q,    cmp_nan_d;
  logic [CNT_WIDTH-1:0]       chk_cnt_q,    chk_cnt_d;
  logic [CNT_WIDTH-1:0]       pass_cnt_q,   pass_cnt_d;
  logic [CNT_WIDTH-1:0]       fail_cnt_q,   fail_cnt_d;
  logic                       overflow_q,   overflow_d;
  logic                       unexpected_q, unexpected_d;
  logic                       done_q,       done_d;
  logic                       success_q,    success_d;

  // Combinational helpers
  logic                       active;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic [TDATA_OUT_WIDTH-1:0] head;

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    cmp_valid_d  = 1'b0;
    cmp_match_d  = 1'b0;
    cmp_unexp_d  = 1'b0;
    cmp_nan_d    = cmp_nan_q;
    chk_cnt_d    = chk_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    overflow_d   = overflow_q;
    unexpected_d = unexpected_q;

    // Once DONE, both streams are ignored and all status is frozen.
    active     = (state_q != ST_DONE);
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    push       = active && s_if.i_golden_tvalid && !fifo_full;
    pop        = active && s_if.i_axi4s_result_tvalid && !fifo_empty;
    head       = mem_q[rd_ptr_q];

    // Golden FIFO. Pop decisions use only entries present at the start of
    // the cycle, so a same-cycle push is never compared against.
    if (push) begin
      mem_d[wr_ptr_q] = s_if.i_golden_tdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    if (active && s_if.i_golden_tvalid && fifo_full) begin
      overflow_d = 1'b1;
    end

    // Compare stage: capture the verdict now, account for it next cycle.
    if (active && s_if.i_axi4s_result_tvalid) begin
      cmp_valid_d = 1'b1;
      cmp_unexp_d = fifo_empty;
      cmp_match_d = !fifo_empty && words_match(head, s_if.i_axi4s_result_tdata);
      cmp_nan_d   = !fifo_empty && is_nan(head) && is_nan(s_if.i_axi4s_result_tdata);
    end

    // Accounting stage. A verdict still in flight when DONE is reached is
    // dropped so counters freeze at exactly VECTOR_NUM checks.
    if (cmp_valid_q && active) begin
      chk_cnt_d = chk_cnt_q + CNT_WIDTH'(1);
      if (cmp_unexp_q) begin
        unexpected_d = 1'b1;
        fail_cnt_d   = (&fail_cnt_q) ? fail_cnt_q : fail_cnt_q + CNT_WIDTH'(1);
      end else if (cmp_match_q) begin
        pass_cnt_d   = (&pass_cnt_q) ? pass_cnt_q : pass_cnt_q + CNT_WIDTH'(1);
      end else begin
        fail_cnt_d   = (&fail_cnt_q) ? fail_cnt_q : fail_cnt_q + CNT_WIDTH'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (push || s_if.i_axi4s_result_tvalid) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (chk_cnt_d == VEC_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    done_d    = (state_d == ST_DONE);
    success_d = done_d && (fail_cnt_d == '0) && !overflow_d && !unexpected_d;
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_match_q  <= 1'b0;
      cmp_unexp_q  <= 1'b0;
      cmp_nan_q    <= 1'b0;
      chk_cnt_q    <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      unexpected_q <= 1'b0;
      done_q       <= 1'b0;
      success_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_match_q  <= cmp_match_d;
      cmp_unexp_q  <= cmp_unexp_d;
      cmp_nan_q    <= cmp_nan_d;
      chk_cnt_q    <= chk_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      overflow_q   <= overflow_d;
      unexpected_q <= unexpected_d;
      done_q       <= done_d;
      success_q    <= success_d;
    end
  end

  // Ready stays high in DONE so the stimulus side never stalls.
  assign s_if.o_golden_tready = (state_q == ST_DONE) || (count_q != FULL_CNT);

  assign o_pass_cnt       = pass_cnt_q;
  assign o_fail_cnt       = fail_cnt_q;
  assign o_overflow       = overflow_q;
  assign o_unexpected     = unexpected_q;
  assign o_done           = done_q;
  assign o_success        = success_q;
  assign o_dbg_state      = state_q;
  assign o_dbg_fifo_count = count_q;
  assign o_dbg_nan_pair   = cmp_nan_q;

endmodule

// File: tb/tb_ipsxe_floating_point_result_checker_v1_0.sv
// ----------------------------------------------------------------------------
// Testbench for ipsxe_floating_point_result_checker_v1_0.
// A per-edge reference model (golden queue plus counters) predicts the status
// outputs after every clock edge; the driver pushes each prediction into
// exp_q and an independent monitor pops and compares one entry per cycle.
// Directed checks cover the reset values and the scenario end states.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ipsxe_floating_point_result_checker_v1_0;

  localparam int TW    = 32;
  localparam int EW    = 8;
  localparam int MW    = 23;
  localparam int DEPTH = 16;
  localparam int VN    = 40;
  localparam int CW    = 16;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int SW    = 2*CW + 5 + OW;

`ifdef IPSXE_FLT_CHECKER_NAN_EQ_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ipsxe_floating_point_result_checker_v1_0_if #(.TDATA_OUT_WIDTH(TW)) chk_if();

  logic [CW-1:0] o_pass_cnt;
  logic [CW-1:0] o_fail_cnt;
  logic          o_overflow;
  logic          o_unexpected;
  logic          o_done;
  logic          o_success;
  logic [1:0]    o_dbg_state;
  logic [OW-1:0] o_dbg_fifo_count;
  logic          o_dbg_nan_pair;

  ipsxe_floating_point_result_checker_v1_0 #(
    .TDATA_OUT_WIDTH(TW), .EXP_WIDTH(EW), .MAN_WIDTH(MW),
    .FIFO_DEPTH(DEPTH), .VECTOR_NUM(VN), .CNT_WIDTH(CW)
  ) dut (
    .i_aclk           (clk),
    .i_areset_n       (rst_n),
    .s_if             (chk_if.slave),
    .o_pass_cnt       (o_pass_cnt),
    .o_fail_cnt       (o_fail_cnt),
    .o_overflow       (o_overflow),
    .o_unexpected     (o_unexpected),
    .o_done           (o_done),
    .o_success        (o_success),
    .o_dbg_state      (o_dbg_state),
    .o_dbg_fifo_count (o_dbg_fifo_count),
    .o_dbg_nan_pair   (o_dbg_nan_pair)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int max_count = 0;
  logic [SW-1:0] exp_q[$];

  // Reference model
  logic [TW-1:0] gq[$];
  logic [CW-1:0] m_pass, m_fail;
  bit m_ovf, m_unexp, m_done;
  int m_accepted, m_checked;
  bit pend_v, pend_m, pend_u;

  function automatic bit ref_is_nan(input logic [TW-1:0] w);
    longint unsigned e, m;
    e = (longint'(w) >> MW) & ((64'd1 << EW) - 1);
    m = longint'(w) & ((64'd1 << MW) - 1);
    return (e == (64'd1 << EW) - 1) && (m != 0);
  endfunction

  function automatic bit ref_eq(input logic [TW-1:0] g, input logic [TW-1:0] r);
    if (g === r) return 1'b1;
    return NAN_EN && ref_is_nan(g) && ref_is_nan(r);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic model_reset();
    gq.delete();
    m_pass = '0; m_fail = '0;
    m_ovf = 0; m_unexp = 0; m_done = 0;
    m_accepted = 0; m_checked = 0;
    pend_v = 0; pend_m = 0; pend_u = 0;
  endtask

  // Effect of one clock edge with the given inputs; pushes the status the
  // DUT must show right after that edge.
  task automatic model_step(input bit gv, input logic [TW-1:0] gd,
                            input bit rv, input logic [TW-1:0] rd);
    int sz;
    bit np_v, np_m, np_u, success, tready;
    logic [TW-1:0] g;
    sz = gq.size();
    np_v = 0; np_m = 0; np_u = 0;
    if (!m_done) begin
      if (rv) begin
        if (sz > 0) begin
          g = gq.pop_front();
          if (m_accepted < VN) begin
            np_v = 1; np_m = ref_eq(g, rd); m_accepted++;
          end
        end else if (m_accepted < VN) begin
          np_v = 1; np_u = 1; m_accepted++;
        end
      end
      if (gv) begin
        if (sz < DEPTH) gq.push_back(gd);
        else m_ovf = 1;
      end
    end
    // The result accepted one edge earlier becomes visible now.
    if (pend_v) begin
      if (pend_u) begin m_unexp = 1; m_fail = sat_inc(m_fail); end
      else if (pend_m) m_pass = sat_inc(m_pass);
      else m_fail = sat_inc(m_fail);
      m_checked++;
      if (m_checked == VN) m_done = 1;
    end
    pend_v = np_v; pend_m = np_m; pend_u = np_u;
    success = m_done && (m_fail == 0) && !m_ovf && !m_unexp;
    tready  = m_done || (gq.size() != DEPTH);
    exp_q.push_back({m_pass, m_fail, m_ovf, m_unexp, m_done, success, tready,
                     OW'(gq.size())});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit gv, input logic [TW-1:0] gd,
                       input bit rv, input logic [TW-1:0] rd);
    @(negedge clk);
    chk_if.i_golden_tvalid       = gv;
    chk_if.i_golden_tdata        = gd;
    chk_if.i_axi4s_result_tvalid = rv;
    chk_if.i_axi4s_result_tdata  = rd;
    model_step(gv, gd, rv, rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pass_cnt"},   64'(o_pass_cnt),   64'd0);
    check({tag, "_fail_cnt"},   64'(o_fail_cnt),   64'd0);
    check({tag, "_overflow"},   64'(o_overflow),   64'd0);
    check({tag, "_unexpected"}, 64'(o_unexpected), 64'd0);
    check({tag, "_done"},       64'(o_done),       64'd0);
    check({tag, "_success"},    64'(o_success),    64'd0);
    check({tag, "_tready"},     64'(chk_if.o_golden_tready), 64'd1);
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    chk_if.i_golden_tvalid = 1'b0;
    chk_if.i_axi4s_result_tvalid = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    model_reset();
    max_count = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [SW-1:0] e, a;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {o_pass_cnt, o_fail_cnt, o_overflow, o_unexpected, o_done, o_success,
           chk_if.o_golden_tready, o_dbg_fifo_count};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL status @%0t: got {pass,fail,ovf,unexp,done,succ,rdy,cnt}=0x%0h expected 0x%0h",
                 $time, a, e);
      end
      if (int'(o_dbg_fifo_count) > max_count) max_count = int'(o_dbg_fifo_count);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [TW-1:0] vec [VN];
    logic [TW-1:0] rd;
    bit gv, rv;

    chk_if.i_golden_tvalid = 1'b0;
    chk_if.i_golden_tdata  = '0;
    chk_if.i_axi4s_result_tvalid = 1'b0;
    chk_if.i_axi4s_result_tdata  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;

    // Basic pass: matching results at latency 14
    for (int t = 0; t < VN + 18; t++) begin
      drive(t < VN, 32'h3F80_0000 + 32'(t),
            (t >= 14) && (t - 14 < VN), 32'h3F80_0000 + 32'(t - 14));
    end
    idle(3);
    check("basic_pass_cnt", 64'(o_pass_cnt), 64'(VN));
    check("basic_fail_cnt", 64'(o_fail_cnt), 64'd0);
    check("basic_done",     64'(o_done),     64'd1);
    check("basic_success",  64'(o_success),  64'd1);

    // Single mismatch: result 5 corrupted to zero
    apply_reset("rst1");
    for (int t = 0; t < VN + 18; t++) begin
      rd = (t - 14 == 5) ? 32'h0 : 32'h3F80_0000 + 32'(t - 14);
      drive(t < VN, 32'h3F80_0000 + 32'(t), (t >= 14) && (t - 14 < VN), rd);
    end
    idle(3);
    check("mism_pass_cnt", 64'(o_pass_cnt), 64'(VN - 1));
    check("mism_fail_cnt", 64'(o_fail_cnt), 64'd1);
    check("mism_done",     64'(o_done),     64'd1);
    check("mism_success",  64'(o_success),  64'd0);

    // FIFO full, then a misbehaving source pushes while not ready
    apply_reset("rst2");
    for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, 1'b0, '0);
    idle(1);
    check("full_tready",   64'(chk_if.o_golden_tready), 64'd0);
    check("full_overflow", 64'(o_overflow), 64'd0);
    check("full_count",    64'(o_dbg_fifo_count), 64'(DEPTH));
    drive(1'b1, 32'hDEAD_0017, 1'b0, '0);
    idle(1);
    check("ovf_overflow",  64'(o_overflow), 64'd1);
    check("ovf_count",     64'(o_dbg_fifo_count), 64'(DEPTH));

    // Unexpected result on empty FIFO with same-cycle push
    apply_reset("rst3");
    drive(1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678);
    idle(2);
    check("unexp_flag",  64'(o_unexpected), 64'd1);
    check("unexp_fail",  64'(o_fail_cnt),   64'd1);
    check("unexp_count", 64'(o_dbg_fifo_count), 64'd1);
    drive(1'b0, '0, 1'b1, 32'h1234_5678);
    idle(2);
    check("unexp_then_pass", 64'(o_pass_cnt), 64'd1);

    // Streaming at latency 3 with pointer wrap
    apply_reset("rst4");
    for (int i = 0; i < VN; i++) vec[i] = $urandom;
    for (int t = 0; t < VN + 6; t++) begin
      drive(t < VN, vec[t % VN], (t >= 3) && (t - 3 < VN), vec[(t + VN - 3) % VN]);
    end
    idle(2);
    check("wrap_pass",      64'(o_pass_cnt), 64'(VN));
    check("wrap_success",   64'(o_success),  64'd1);
    check("wrap_max_count", 64'(max_count <= 4), 64'd1);

    // NaN pair compare
    apply_reset("rst5");
    drive(1'b1, 32'h7FC0_0000, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'hFFC0_0001);
    @(posedge clk); #1;
    check("nan_pair_flag", 64'(o_dbg_nan_pair), 64'd1);
    idle(3);
    check("nan_pass", 64'(o_pass_cnt), NAN_EN ? 64'd1 : 64'd0);
    check("nan_fail", 64'(o_fail_cnt), NAN_EN ? 64'd0 : 64'd1);

    // Random traffic, reset in the middle of RUN, then random to completion
    apply_reset("rst6");
    for (int pass_i = 0; pass_i < 2; pass_i++) begin
      for (int t = 0; t < (pass_i == 0 ? 30 : 320); t++) begin
        gv = ($urandom_range(0, 1) == 1);
        rv = ($urandom_range(0, 2) == 0);
        if (gq.size() > 0 && $urandom_range(0, 3) != 0) rd = gq[0];
        else rd = $urandom;
        drive(gv, $urandom, rv, rd);
      end
      idle(2);
      if (pass_i == 0) apply_reset("mid_run");
    end
    check("rand_done", 64'(o_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
